multicycle_ctrl_fsm: RTL
========================

Name: multicycle_ctrl_fsm

Overview:
- Next-generation multicycle MIPS-subset control unit, replacing the fixed control FSM.
- Adds I-type ALU ops, BNE, JAL, a memory ready/wait handshake with a timeout fault, an illegal-opcode fault and a retired-instruction counter.
- Sits beside the datapath inside the CPU top; the datapath supplies opcode, memory ready and ALU zero.

Parameters:
MAX_WAIT, 15, max stall cycles per memory state before fault; 0 = wait forever
CNT_W, 16, width of retired-instruction counter
MEM_HANDSHAKE, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
op  in  6  IR[31:26] from datapath
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  conditional PC load; datapath loads PC when pc_write_cond & (zero ^ branch_invert)
branch_invert  out  1  1 for BNE
i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
reg_dst  out  2  00 rt, 01 rd, 10 r31
reg_write  out  1  register file write
alu_src_a  out  1  0 PC, 1 A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
alu_op  out  4  ALU operation code from package
pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
fault  out  1  sticky; FSM halted
illegal_op  out  1  sticky; cause was an undecodable opcode
instr_count  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset (sync, high): state <= FETCH, wait counter <= 0, instr_count <= 0, fault/illegal_op <= 0. While reset is high, every control output is 0.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, RTYPE_WB, EXEC_I, ITYPE_WB, BRANCH, JUMP, JAL, FAULT.
- FETCH: mem_read=1, alu_src_b=01, alu_op=ADD.
  - ir_write and pc_write are asserted only in the cycle where mem_ready=1; these are the only Mealy terms.
  - Stay in FETCH while mem_ready=0; go to DECODE on mem_ready.
- DECODE: alu_src_b=11, alu_op=ADD. Next state by op:
  - LW 0x23 or SW 0x2B -> MEMADR
  - R 0x00 -> EXEC_R
  - ADDI 0x08, SLTI 0x0A, ANDI 0x0C, ORI 0x0D -> EXEC_I
  - BEQ 0x04 or BNE 0x05 -> BRANCH
  - J 0x02 -> JUMP
  - JAL 0x03 -> JAL
  - any other op -> FAULT, with illegal_op set
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Next: MEMRD for LW, MEMWR for SW.
- MEMRD: mem_read=1, i_or_d=1. Waits on mem_ready, then -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=01, reg_dst=00. Next: FETCH.
- MEMWR: mem_write=1, i_or_d=1. Waits on mem_ready, then -> FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=FUNCT. Next: RTYPE_WB (reg_write=1, reg_dst=01), then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op = ADD/SLT/AND/OR for ADDI/SLTI/ANDI/ORI. Next: ITYPE_WB (reg_write=1, reg_dst=00), then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01, branch_invert = (op==BNE). Next: FETCH.
- JUMP: pc_write=1, pc_source=10. Next: FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10. The register write captures the already-incremented PC. Next: FETCH.
- Unlisted outputs are 0 in every state.
- Latency with zero wait states: LW 5; SW, R, I-type 4; BEQ, BNE, J, JAL 3. Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds 1.
- Wait counter:
  - Clears on entering a memory state and on mem_ready=1.
  - Increments on each cycle with mem_ready=0.
  - If MAX_WAIT>0 and the counter equals MAX_WAIT while mem_ready=0 -> FAULT.
  - Counter width is clog2(MAX_WAIT+1); it saturates and never wraps.
- FAULT: all control outputs 0; fault=1; exits only on reset.
- instr_count increments by 1 on each transition into FETCH from a non-FAULT state other than FETCH itself. Wraps modulo 2^CNT_W.
- Reset mid-instruction aborts it; no strobe is asserted in the reset cycle.
- mem_ready in a non-memory state is ignored.

Decomposition:
- Package mcpu_pkg holds:
  - state enum
  - opcode constants
  - ALU op codes: ADD=0, SUB=1, AND=2, OR=3, SLT=4, FUNCT=15
  - mux-select constants for mem_to_reg, reg_dst, alu_src_b, pc_source
- Sub-module mem_wait_timer: the wait counter plus timeout compare, parametrised by MAX_WAIT.

Test Plan:
- LW, mem_ready always 1 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; reg_write=1 with mem_to_reg=01 in cycle 5; instr_count 0->1.
- R-type with mem_ready low for 3 cycles in FETCH -> ir_write/pc_write 0 for 3 cycles, then 1; total 7 cycles; alu_op=15 in EXEC_R.
- BNE -> BRANCH state asserts pc_write_cond=1, branch_invert=1, pc_source=01; BEQ same with branch_invert=0; both take 3 cycles.
- JAL -> pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10 in the same cycle; back in FETCH next cycle.
- op=0x3F -> FAULT after DECODE; illegal_op=1, fault=1, all strobes 0 for 20 cycles; reset returns to FETCH with count 0.
- MAX_WAIT=4, SW with mem_ready held 0 in MEMWR -> FAULT after the 5th stall cycle, illegal_op=0; repeat with MAX_WAIT=0 -> still waiting after 100 cycles, no fault.

Source files
------------

// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - shared state, opcode, ALU and mux-select constants for the multicycle control unit
package mcpu_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMRD    = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWR    = 4'd5;
  localparam state_t S_EXEC_R   = 4'd6;
  localparam state_t S_RTYPE_WB = 4'd7;
  localparam state_t S_EXEC_I   = 4'd8;
  localparam state_t S_ITYPE_WB = 4'd9;
  localparam state_t S_BRANCH   = 4'd10;
  localparam state_t S_JUMP     = 4'd11;
  localparam state_t S_JAL      = 4'd12;
  localparam state_t S_FAULT    = 4'd13;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_SLT   = 4'd4;
  localparam logic [3:0] ALU_FUNCT = 4'd15;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:                       return S_MEMADR;
      OP_R:                               return S_EXEC_R;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  return S_EXEC_I;
      OP_BEQ, OP_BNE:                     return S_BRANCH;
      OP_J:                               return S_JUMP;
      OP_JAL:                             return S_JAL;
      default:                            return S_FAULT;
    endcase
  endfunction

  function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating stall counter with timeout compare for memory-wait states
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  input  logic clear,
  output logic timeout
);

  localparam int W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear || ready || !active)
      cnt <= '0;
    else if (cnt != {W{1'b1}})
      cnt <= cnt + W'(1);
  end

  // MAX_WAIT of zero disables the timeout; the counter still saturates harmlessly.
  assign timeout = (MAX_WAIT > 0) && active && !ready && (cnt == W'(MAX_WAIT));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle MIPS-subset control FSM with memory wait, faults and retire counter
module multicycle_ctrl_fsm #(
  parameter int MAX_WAIT      = 15,
  parameter int CNT_W         = 16,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_invert,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             fault,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);
  import mcpu_pkg::*;

  state_t state, next_state;
  logic   rdy, in_mem, timeout, illegal_q, retire;

  assign rdy    = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign in_mem = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign retire = (next_state == S_FETCH) && (state != S_FETCH) && (state != S_FAULT);

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .active  (in_mem),
    .ready   (rdy),
    .clear   (next_state != state),
    .timeout (timeout)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    next_state = timeout ? S_FAULT : (rdy ? S_DECODE : S_FETCH);
      S_DECODE:   next_state = decode_next(op);
      S_MEMADR:   next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    next_state = timeout ? S_FAULT : (rdy ? S_MEMWB : S_MEMRD);
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWR:    next_state = timeout ? S_FAULT : (rdy ? S_FETCH : S_MEMWR);
      S_EXEC_R:   next_state = S_RTYPE_WB;
      S_RTYPE_WB: next_state = S_FETCH;
      S_EXEC_I:   next_state = S_ITYPE_WB;
      S_ITYPE_WB: next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
      S_JAL:      next_state = S_FETCH;
      S_FAULT:    next_state = S_FAULT;
      default:    next_state = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      illegal_q   <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE && next_state == S_FAULT)
        illegal_q <= 1'b1;
      if (retire)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Outputs are forced low during reset so an aborted instruction never strobes.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_invert = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = M2R_ALUOUT;
    reg_dst       = DST_RT;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCS_ALU;
    fault         = 1'b0;
    illegal_op    = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = rdy;
          pc_write  = rdy;
        end
        S_DECODE: alu_src_b = SRCB_BOFF;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_MDR;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_RTYPE_WB: begin
          reg_write = 1'b1;
          reg_dst   = DST_RD;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = imm_alu_op(op);
        end
        S_ITYPE_WB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCS_ALUOUT;
          branch_invert = (op == OP_BNE);
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCS_JUMP;
        end
        S_JAL: begin
          pc_write   = 1'b1;
          pc_source  = PCS_JUMP;
          reg_write  = 1'b1;
          reg_dst    = DST_R31;
          mem_to_reg = M2R_PC;
        end
        S_FAULT: begin
          fault      = 1'b1;
          illegal_op = illegal_q;
        end
        default: ;
      endcase
    end
  end

endmodule
